// File: rtl/eq_output_stage.sv
// eq_output_stage: rounds and saturates EQ filter results to OUT_W-bit samples and
// streams them as left-justified mono frames on BCLK/LRCLK/SDATA.
module eq_output_stage #(
  parameter int RESULT_W = 42,
  parameter int OUT_W    = 24,
  parameter int SHIFT    = 15,
  parameter int BCLK_DIV = 4,
  parameter int SLOT_W   = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [RESULT_W-1:0] i_result,
  input  logic                i_ready,
  output logic                o_bclk,
  output logic                o_lrclk,
  output logic                o_sdata,
  output logic [OUT_W-1:0]    o_sample,
  output logic                o_sat,
  output logic                o_overrun,
  output logic                o_underrun
);

  localparam int SUM_W = RESULT_W + 1;
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam logic signed [SUM_W-1:0] RND_C = SUM_W'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [SUM_W-1:0] MAX_C = SUM_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] MIN_C = SUM_W'(-(64'sd1 <<< (OUT_W - 1)));
  localparam logic [DIV_W-1:0] DIV_LAST_C  = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST_C  = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] SLOT_LAST_C = BIT_W'(SLOT_W - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Returns {saturated, sample}: round half up, arithmetic shift, clamp.
  function automatic logic [OUT_W:0] round_sat(input logic [RESULT_W-1:0] res);
    logic signed [SUM_W-1:0] sum_v;
    logic signed [SUM_W-1:0] shr_v;
    logic [OUT_W:0]          out_v;
    sum_v = $signed({res[RESULT_W-1], res}) + RND_C;
    shr_v = sum_v >>> SHIFT;
    if (shr_v > MAX_C) begin
      out_v = {1'b1, OUT_W'(MAX_C)};
    end else if (shr_v < MIN_C) begin
      out_v = {1'b1, OUT_W'(MIN_C)};
    end else begin
      out_v = {1'b0, OUT_W'(shr_v)};
    end
    return out_v;
  endfunction

  function automatic logic [SLOT_W-1:0] load_word(input logic [OUT_W-1:0] smp);
    return SLOT_W'(smp) << (SLOT_W - OUT_W);
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic                ready_d_r;
  logic                cap_v_r;
  logic [RESULT_W-1:0] cap_result_r;
  logic                pending_r;
  logic [DIV_W-1:0]    div_r;
  logic [BIT_W-1:0]    bit_cnt_r;
  logic [SLOT_W-1:0]   shreg_r;
  logic [OUT_W-1:0]    frame_word_r;
  logic [OUT_W:0]      conv_s;
  logic                capture_s;
  logic                div_tc_s;
  logic                bclk_fall_s;
  logic                wrap_s;
  logic                slot_s;
  logic                run_entry_s;
  logic                frame_start_s;
  logic                active_s;

  assign o_sdata = shreg_r[SLOT_W-1];

  // Edge detect, conversion and BCLK event decode.
  always_comb begin
    capture_s   = i_ready & ~ready_d_r;
    conv_s      = round_sat(cap_result_r);
    div_tc_s    = (div_r == DIV_LAST_C);
    bclk_fall_s = div_tc_s & o_bclk;
    wrap_s      = bclk_fall_s & (bit_cnt_r == BIT_LAST_C);
    slot_s      = bclk_fall_s & (bit_cnt_r == SLOT_LAST_C);
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: leave IDLE once a sample is pending, then run until reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = pending_r ? RUN : IDLE;
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: frame start strobes and serialiser enable.
  always_comb begin
    run_entry_s   = 1'b0;
    frame_start_s = 1'b0;
    active_s      = 1'b0;
    case (state_r)
      IDLE: begin
        run_entry_s   = pending_r;
        frame_start_s = pending_r;
      end
      RUN: begin
        active_s      = 1'b1;
        frame_start_s = wrap_s;
      end
      default: begin
        run_entry_s   = 1'b0;
        frame_start_s = 1'b0;
        active_s      = 1'b0;
      end
    endcase
  end

  // Capture stage: latch the filter result on the rising edge of i_ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_d_r    <= 1'b0;
      cap_v_r      <= 1'b0;
      cap_result_r <= '0;
    end else begin
      ready_d_r    <= i_ready;
      cap_v_r      <= capture_s;
      cap_result_r <= capture_s ? i_result : cap_result_r;
    end
  end

  // Sample register, pending flag and status pulses; a new sample beats a frame-start clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sample   <= '0;
      o_sat      <= 1'b0;
      o_overrun  <= 1'b0;
      o_underrun <= 1'b0;
      pending_r  <= 1'b0;
    end else begin
      o_sample   <= cap_v_r ? conv_s[OUT_W-1:0] : o_sample;
      o_sat      <= cap_v_r & conv_s[OUT_W];
      o_overrun  <= cap_v_r & pending_r & ~frame_start_s;
      o_underrun <= frame_start_s & ~run_entry_s & ~pending_r;
      if (cap_v_r) begin
        pending_r <= 1'b1;
      end else if (frame_start_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Serialiser: BCLK divider, bit counter and left-justified shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_r        <= '0;
      o_bclk       <= 1'b0;
      bit_cnt_r    <= '0;
      o_lrclk      <= 1'b0;
      shreg_r      <= '0;
      frame_word_r <= '0;
    end else if (run_entry_s) begin
      div_r        <= '0;
      o_bclk       <= 1'b0;
      bit_cnt_r    <= '0;
      o_lrclk      <= 1'b0;
      shreg_r      <= load_word(o_sample);
      frame_word_r <= o_sample;
    end else if (active_s) begin
      div_r  <= div_tc_s ? '0 : div_r + DIV_W'(1);
      o_bclk <= div_tc_s ? ~o_bclk : o_bclk;
      if (bclk_fall_s) begin
        bit_cnt_r <= wrap_s ? '0 : bit_cnt_r + BIT_W'(1);
        if (wrap_s) begin
          o_lrclk      <= 1'b0;
          shreg_r      <= load_word(o_sample);
          frame_word_r <= o_sample;
        end else if (slot_s) begin
          o_lrclk <= 1'b1;
          shreg_r <= load_word(frame_word_r);
        end else begin
          shreg_r <= {shreg_r[SLOT_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_eq_output_stage.sv
// Randomized bench for eq_output_stage: arithmetic reference for conversion and a
// per-frame model (latest sample, overrun/underrun counts) checked against the decoded stream.
module tb_eq_output_stage;

  localparam int RESULT_W = 42;
  localparam int OUT_W    = 24;
  localparam int SHIFT    = 15;
  localparam int BCLK_DIV = 4;
  localparam int SLOT_W   = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [RESULT_W-1:0] i_result;
  logic                i_ready;
  logic                o_bclk, o_lrclk, o_sdata, o_sat, o_overrun, o_underrun;
  logic [OUT_W-1:0]    o_sample;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ov  = 0;
  int n_un  = 0;
  int exp_ov, exp_un;
  logic [OUT_W-1:0] last_sample;
  logic [OUT_W-1:0] exp_q[$];

  typedef struct {
    logic              lr;
    logic [SLOT_W-1:0] w;
    int                bits;
  } word_t;
  word_t             word_q[$];
  logic [SLOT_W-1:0] mon_word;
  int                mon_bits;
  logic              mon_lr;
  logic              prev_bclk;

  eq_output_stage #(
    .RESULT_W(RESULT_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .BCLK_DIV(BCLK_DIV), .SLOT_W(SLOT_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_result(i_result), .i_ready(i_ready),
    .o_bclk(o_bclk), .o_lrclk(o_lrclk), .o_sdata(o_sdata), .o_sample(o_sample),
    .o_sat(o_sat), .o_overrun(o_overrun), .o_underrun(o_underrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference conversion: floor((x + half LSB) / 2^SHIFT), then clamp.
  task automatic ref_conv(input logic [RESULT_W-1:0] x, output logic [OUT_W-1:0] smp, output logic sat);
    longint xv, q, r, one, hi, lo;
    xv  = $signed(x);
    one = longint'(1) <<< SHIFT;
    q   = xv + (one / 2);
    if (q >= 0) r = q / one;
    else        r = -((-q + one - 1) / one);
    hi  = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo  = -hi - 1;
    sat = 1'b0;
    if (r > hi) begin r = hi; sat = 1'b1; end
    if (r < lo) begin r = lo; sat = 1'b1; end
    smp = r[OUT_W-1:0];
  endtask

  function automatic logic [RESULT_W-1:0] gen_x();
    longint      v;
    logic [63:0] raw;
    case ($urandom_range(0, 3))
      0: v = longint'($urandom_range(0, 1048575)) - 524288;
      1: v = (longint'($urandom_range(0, 4095)) - 2048) * 32768 + 16383 + longint'($urandom_range(0, 2));
      2: v = (longint'($urandom_range(0, 255)) - 128) <<< 32;
      default: begin raw = {$urandom, $urandom}; v = longint'(raw); end
    endcase
    return v[RESULT_W-1:0];
  endfunction

  task automatic do_conv(input string tag, input logic [RESULT_W-1:0] x);
    logic [OUT_W-1:0] es;
    logic             esat;
    ref_conv(x, es, esat);
    @(posedge clk); #1;
    i_result = x;
    i_ready  = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_latency"}, o_sample, last_sample);
    @(posedge clk); #1;
    check_eq(tag, o_sample, es);
    check_eq({tag, "_sat"}, o_sat, esat);
    i_ready = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_satpulse"}, o_sat, 1'b0);
    last_sample = es;
  endtask

  // Single capture pulse mid-frame; the model only tracks which value is latest.
  task automatic quick_capture(input logic [RESULT_W-1:0] x);
    logic [OUT_W-1:0] es;
    logic             esat;
    ref_conv(x, es, esat);
    @(posedge clk); #1;
    i_result = x;
    i_ready  = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    repeat (2) @(posedge clk);
    last_sample = es;
  endtask

  task automatic wait_lr_edge(input logic lvl, input string tag);
    logic prev;
    int   n;
    prev = o_lrclk;
    n    = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (prev != lvl && o_lrclk == lvl) break;
      prev = o_lrclk;
    end
    check_eq(tag, (n < 2000), 1'b1);
  endtask

  // Stream decoder: one word per LRCLK level, bits taken on BCLK rising edges.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_bits  = 0;
      mon_word  = '0;
      prev_bclk = 1'b0;
    end else begin
      if (o_overrun)  n_ov++;
      if (o_underrun) n_un++;
      if (o_bclk && !prev_bclk) begin
        if (mon_bits > 0 && o_lrclk != mon_lr) begin
          word_q.push_back('{lr: mon_lr, w: mon_word, bits: mon_bits});
          mon_bits = 0;
          mon_word = '0;
        end
        mon_word = {mon_word[SLOT_W-2:0], o_sdata};
        mon_lr   = o_lrclk;
        mon_bits++;
      end
      prev_bclk = o_bclk;
    end
  end

  initial begin
    logic              busy;
    int                ncap;
    logic [SLOT_W-1:0] ew;
    longint            sv;

    rst_n = 1'b0; i_result = '0; i_ready = 1'b0; last_sample = '0;
    #2;
    check_eq("rst_sample", o_sample, 24'd0);
    check_eq("rst_bclk", o_bclk, 1'b0);
    check_eq("rst_lrclk", o_lrclk, 1'b0);
    check_eq("rst_sdata", o_sdata, 1'b0);
    check_eq("rst_flags", {o_sat, o_overrun, o_underrun}, 3'b000);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;

    do_conv("t1_one", 42'd32768);
    do_conv("t2_half_up", 42'd49152);
    do_conv("t2_neg_half", RESULT_W'(-64'sd49152));
    do_conv("t2_below_half", 42'd16383);
    do_conv("t3_pos_sat", 42'h0FF_FFFF_FFFF);
    do_conv("t3_neg_sat", RESULT_W'(-(64'sd1 <<< 40)));
    repeat (30) do_conv("rnd_conv", gen_x());

    // Reset in the middle of the right slot.
    wait_lr_edge(1'b1, "pre_rst_lr");
    repeat (37) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_sample", o_sample, 24'd0);
    check_eq("midrst_serial", {o_bclk, o_lrclk, o_sdata}, 3'b000);
    check_eq("midrst_flags", {o_sat, o_overrun, o_underrun}, 3'b000);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    last_sample = '0;
    busy = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (o_bclk | o_lrclk | o_sdata) busy = 1'b1;
    end
    check_eq("idle_after_rst", busy, 1'b0);

    // Serial phase: frame model driven by mid-frame captures.
    n_ov = 0; n_un = 0; exp_ov = 0; exp_un = 0;
    word_q.delete();
    exp_q.delete();
    sv = longint'(24'hA5A5A5) - (longint'(1) <<< OUT_W);
    do_conv("t4_a5", RESULT_W'(sv * 32768));
    exp_q.push_back(24'hA5A5A5);
    for (int i = 0; i < 8; i++) begin
      wait_lr_edge(1'b1, "frame_lr_rise");
      ncap = (i == 0) ? 0 : (i == 1) ? 2 : int'($urandom_range(0, 2));
      for (int c = 0; c < ncap; c++) quick_capture(gen_x());
      if (ncap == 0) begin
        exp_un++;
        exp_q.push_back(exp_q[$]);
      end else begin
        exp_ov += ncap - 1;
        exp_q.push_back(last_sample);
      end
    end
    wait_lr_edge(1'b1, "last_lr_rise");
    wait_lr_edge(1'b0, "last_lr_fall");
    exp_un++;
    repeat (40) @(posedge clk); #1;

    check_eq("word_count", word_q.size(), 2 * exp_q.size());
    for (int f = 0; f < exp_q.size(); f++) begin
      ew = {exp_q[f], {(SLOT_W-OUT_W){1'b0}}};
      for (int s = 0; s < 2; s++) begin
        if (2 * f + s < word_q.size()) begin
          check_eq($sformatf("f%0d_s%0d_lr", f, s), word_q[2*f+s].lr, s[0]);
          check_eq($sformatf("f%0d_s%0d_bits", f, s), word_q[2*f+s].bits, SLOT_W);
          check_eq($sformatf("f%0d_s%0d_word", f, s), word_q[2*f+s].w, ew);
        end
      end
    end
    check_eq("overrun_count", n_ov, exp_ov);
    check_eq("underrun_count", n_un, exp_un);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
